// File: rtl/cfg_write_arbiter.sv
// Configuration register file with a shared write port: two requesters are
// arbitrated round-robin, and writes to addresses above MAX_ADDR are rejected and counted.
module cfg_write_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int MAX_ADDR = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              wr_src,
  output logic [7:0]        err_count,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4
);

  localparam int NUM_REGS = 5;

  typedef enum logic {ARB, COMMIT} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_src_q, hold_src_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_src_q, wr_src_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              grant_a, grant_b;
  logic              addr_ok;

  // ptr_q names the requester that wins a tie: 0 = A, 1 = B.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_src_d  = hold_src_q;
    regs_d      = regs_q;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;
    wr_src_d    = wr_src_q;
    err_count_d = err_count_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    addr_ok     = (hold_addr_q <= ADDR_W'(MAX_ADDR));

    case (state_q)
      ARB: begin
        grant_a = a_valid && (!b_valid || !ptr_q);
        grant_b = b_valid && (!a_valid || ptr_q);
        if (grant_a) begin
          hold_addr_d = a_addr;
          hold_data_d = a_data;
          hold_src_d  = 1'b0;
          state_d     = COMMIT;
        end else if (grant_b) begin
          hold_addr_d = b_addr;
          hold_data_d = b_data;
          hold_src_d  = 1'b1;
          state_d     = COMMIT;
        end
      end
      COMMIT: begin
        if (addr_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (hold_addr_q == ADDR_W'(i)) regs_d[i] = hold_data_q;
          end
          wr_ack_d = 1'b1;
        end else begin
          wr_err_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        wr_src_d = hold_src_q;
        ptr_d    = ~hold_src_q;
        state_d  = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_src_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      wr_src_q    <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_src_q  <= hold_src_d;
      regs_q      <= regs_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      wr_src_q    <= wr_src_d;
      err_count_q <= err_count_d;
    end
  end

  // Readies are forced low during reset even though valids may be asserted.
  assign a_ready   = grant_a && !rst;
  assign b_ready   = grant_b && !rst;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign wr_src    = wr_src_q;
  assign err_count = err_count_q;
  assign data0     = regs_q[0];
  assign data1     = regs_q[1];
  assign data2     = regs_q[2];
  assign data3     = regs_q[3];
  assign data4     = regs_q[4];

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter: requesters are modelled as queues of pending writes,
// and a request-level reference model predicts grants, register contents and status.
module tb_cfg_write_arbiter;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int MAX_ADDR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              wr_ack, wr_err, wr_src;
  logic [7:0]        err_count;
  logic [DATA_W-1:0] data0, data1, data2, data3, data4;

  always #5 clk = ~clk;

  cfg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_ack(wr_ack), .wr_err(wr_err), .wr_src(wr_src), .err_count(err_count),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  int checks   = 0;
  int failures = 0;

  req_t        qA[$];
  req_t        qB[$];
  logic        grantLog[$];
  logic [7:0]  expRegs[5];
  logic [7:0]  expErr;
  logic        expAck, expErrP, expSrc;
  logic        favourB;
  logic        busy;
  req_t        pend;
  logic        pendSrc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 5; i++) expRegs[i] = 8'h00;
    expErr  = 8'h00;
    expAck  = 1'b0;
    expErrP = 1'b0;
    expSrc  = 1'b0;
    favourB = 1'b0;
    busy    = 1'b0;
  endtask

  task automatic driveInputs();
    a_valid = (qA.size() != 0);
    b_valid = (qB.size() != 0);
    {a_addr, a_data} = a_valid ? qA[0] : '0;
    {b_addr, b_data} = b_valid ? qB[0] : '0;
  endtask

  function automatic logic expGrantA();
    return !rst && !busy && qA.size() != 0 && (qB.size() == 0 || !favourB);
  endfunction

  function automatic logic expGrantB();
    return !rst && !busy && qB.size() != 0 && (qA.size() == 0 || favourB);
  endfunction

  // Compares every observable output against the reference model at the current time.
  task automatic checkOutput();
    check("a_ready", a_ready, expGrantA());
    check("b_ready", b_ready, expGrantB());
    check("wr_ack", wr_ack, expAck);
    check("wr_err", wr_err, expErrP);
    check("wr_src", wr_src, expSrc);
    check("err_count", err_count, expErr);
    check("data0", data0, expRegs[0]);
    check("data1", data1, expRegs[1]);
    check("data2", data2, expRegs[2]);
    check("data3", data3, expRegs[3]);
    check("data4", data4, expRegs[4]);
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus();
    logic gA, gB;
    @(negedge clk);
    checkOutput();
    gA = expGrantA();
    gB = expGrantB();
    @(posedge clk);
    if (busy) begin
      if (pend.addr <= ADDR_W'(MAX_ADDR)) begin
        expRegs[pend.addr] = pend.data;
        expAck  = 1'b1;
        expErrP = 1'b0;
      end else begin
        expAck  = 1'b0;
        expErrP = 1'b1;
        if (expErr != 8'hFF) expErr = expErr + 8'd1;
      end
      expSrc  = pendSrc;
      favourB = !pendSrc;
      busy    = 1'b0;
    end else begin
      expAck  = 1'b0;
      expErrP = 1'b0;
      if (gA) begin
        pend = qA.pop_front(); pendSrc = 1'b0; busy = 1'b1; grantLog.push_back(1'b0);
      end else if (gB) begin
        pend = qB.pop_front(); pendSrc = 1'b1; busy = 1'b1; grantLog.push_back(1'b1);
      end
    end
    #1;
    driveInputs();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    rst = 1'b1;
    modelReset();
    driveInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;

    // A-only write lands in data2 one cycle after the transfer.
    qA.push_back('{addr: 7'd2, data: 8'hA5});
    driveInputs();
    runCycles(2);
    check("aonly_data2", data2, 8'hA5);
    check("aonly_ack", wr_ack, 1'b1);
    check("aonly_src", wr_src, 1'b0);
    check("aonly_data0", data0, 8'h00);
    runCycles(1);

    // Reset mid-run clears everything and returns priority to A.
    qB.push_back('{addr: 7'd3, data: 8'h99});
    driveInputs();
    applyReset();
    check("rst_data2", data2, 8'h00);
    qB.delete();
    driveInputs();
    runCycles(1);

    // Contention: both held, grants alternate starting with A.
    grantLog.delete();
    qA.push_back('{addr: 7'd0, data: 8'h11});
    qA.push_back('{addr: 7'd1, data: 8'h22});
    qB.push_back('{addr: 7'd3, data: 8'h33});
    qB.push_back('{addr: 7'd4, data: 8'h44});
    driveInputs();
    runCycles(9);
    check("cont_grants", grantLog.size(), 4);
    if (grantLog.size() == 4) begin
      check("cont_g0", grantLog[0], 1'b0);
      check("cont_g1", grantLog[1], 1'b1);
      check("cont_g2", grantLog[2], 1'b0);
      check("cont_g3", grantLog[3], 1'b1);
    end
    check("cont_data0", data0, 8'h11);
    check("cont_data1", data1, 8'h22);
    check("cont_data3", data3, 8'h33);
    check("cont_data4", data4, 8'h44);

    // Invalid addresses, including one that would alias if truncated.
    qB.push_back('{addr: 7'd5, data: 8'hFF});
    driveInputs();
    runCycles(2);
    check("inv5_err", wr_err, 1'b1);
    check("inv5_src", wr_src, 1'b1);
    check("inv5_cnt", err_count, 8'd1);
    runCycles(1);
    qA.push_back('{addr: 7'h45, data: 8'h12});
    qB.push_back('{addr: 7'h7F, data: 8'h00});
    driveInputs();
    runCycles(5);
    check("inv_cnt3", err_count, 8'd3);
    check("inv_data1", data1, 8'h22);

    // Reset arriving during COMMIT discards the write.
    qA.push_back('{addr: 7'd1, data: 8'h5A});
    driveInputs();
    runCycles(1);
    applyReset();
    check("rstc_data1", data1, 8'h00);
    check("rstc_ack", wr_ack, 1'b0);
    grantLog.delete();
    qA.push_back('{addr: 7'd0, data: 8'h01});
    qB.push_back('{addr: 7'd0, data: 8'h02});
    driveInputs();
    runCycles(5);
    check("rstc_first_a", (grantLog.size() > 0) ? grantLog[0] : 1'bx, 1'b0);
    check("rstc_last_wins", data0, 8'h02);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && qA.size() < 3)
        qA.push_back('{addr: 7'($urandom_range(0, 7)), data: 8'($urandom)});
      if ($urandom_range(0, 3) == 0 && qB.size() < 3)
        qB.push_back('{addr: ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5)),
                       data: 8'($urandom)});
      driveInputs();
      applyStimulus();
    end

    // Saturation: many rejected writes pin err_count at 0xFF.
    for (int i = 0; i < 300; i++)
      qB.push_back('{addr: 7'($urandom_range(5, 127)), data: 8'($urandom)});
    driveInputs();
    for (int guard = 0; guard < 2000 && (qA.size() != 0 || qB.size() != 0 || busy); guard++)
      applyStimulus();
    check("sat_drained", qA.size() + qB.size(), 0);
    runCycles(1);
    check("sat_cnt", err_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_write_arbiter.md
Name: cfg_write_arbiter

Overview:
- Owns the five 8-bit configuration registers (addresses 0..4) that drive the design's output-enable/PWM datapath.
- Shares the single register write port between two requesters:
  - requester A: the host path, carrying write frames decoded from the SPI peripheral after synchronisation into clk.
  - requester B: the on-chip configuration sequencer.
- Arbitrates round-robin and checks addresses.
- Reports per-write completion and error status.

Parameters:
- DATA_W, 8, register and write-data width
- ADDR_W, 7, write-address width, matching the SPI frame address field
- MAX_ADDR, 4, highest valid register address; writes above it are rejected

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- a_valid  input  1  requester A has a write pending
- a_addr  input  ADDR_W  requester A target address
- a_data  input  DATA_W  requester A write data
- a_ready  output  1  requester A write accepted this cycle
- b_valid  input  1  requester B has a write pending
- b_addr  input  ADDR_W  requester B target address
- b_data  input  DATA_W  requester B write data
- b_ready  output  1  requester B write accepted this cycle
- wr_ack  output  1  one-cycle pulse: a write was committed to a register
- wr_err  output  1  one-cycle pulse: a write was rejected (address > MAX_ADDR)
- wr_src  output  1  source of the last committed or rejected write (0=A, 1=B)
- err_count  output  8  saturating count of rejected writes
- data0..data4  output  DATA_W each  configuration register contents

Behaviour:
- Reset: rst high asynchronously forces the following:
  - state = ARB, holding registers cleared.
  - priority pointer = A.
  - data0..data4 = 0x00, err_count = 0x00.
  - wr_ack = wr_err = wr_src = 0.
  - Any in-flight write is discarded.
  - a_ready/b_ready are 0 while rst is high.
- Handshake:
  - A transfer occurs on a rising edge where x_valid && x_ready.
  - A requester holds valid, addr and data stable until it completes a transfer.
  - Valid may not be withdrawn without a transfer.
  - x_ready is combinational from state, pointer and both valids. It never depends on x_addr/x_data.
- States: ARB, COMMIT.
- ARB:
  - Neither valid: stay in ARB, both ready low.
  - Only one valid: that requester's ready is high.
  - Both valid: the requester named by the pointer gets ready. The other's ready stays low.
  - On the transfer edge: latch addr, data and source into holding registers, then go to COMMIT.
- COMMIT (exactly one cycle, both ready low):
  - Holding addr <= MAX_ADDR: write holding data to register[addr], assert wr_ack at this edge.
  - Holding addr > MAX_ADDR: registers unchanged; assert wr_err; err_count += 1, saturating at 0xFF (no wrap).
  - wr_src = holding source.
  - Pointer set to the requester that was NOT just served.
  - Return to ARB.
- Latency:
  - Transfer at edge N; register value and wr_ack/wr_err visible after edge N+1.
  - Maximum throughput is one write per 2 cycles.
- Pulse and output rules:
  - wr_ack and wr_err are high for exactly one cycle and never high together.
  - data0..data4 change only at the edge where wr_ack rises.
- Address compare uses the full ADDR_W bits (e.g. 0x45 is invalid, not aliased to 5 or 1).
- Fairness: with both valid held continuously, grants alternate A, B, A, B… A requester waits at most one other write.
- Back-to-back writes to the same address commit in grant order; the last one wins.
- If rst rises during COMMIT, no register write or pulse occurs.

Test Plan:
- Reset values: assert rst mid-run -> all data regs 0x00, err_count 0x00, a_ready=b_ready=0. Release; a single A write is then granted first.
- A-only write: a_addr=2, a_data=0xA5 -> a_ready high in the first ARB cycle. data2=0xA5 and wr_ack=1, wr_src=0 one cycle after the transfer. Other regs unchanged.
- Contention: a_valid and b_valid held with A={0,0x11} then {1,0x22}, B={3,0x33} then {4,0x44} -> grant order A,B,A,B. Final data0=0x11, data1=0x22, data3=0x33, data4=0x44. Four wr_ack pulses 2 cycles apart.
- Invalid address: B writes addr=5, data=0xFF -> wr_err pulse, wr_src=1, err_count=1, all data regs unchanged. addr=0x7F is also rejected.
- Saturation: 300 invalid writes -> err_count stops at 0xFF, wr_err still pulses each time.
- Reset during COMMIT: A transfers addr=1, data=0x5A, rst pulsed in the COMMIT cycle -> data1=0x00, no wr_ack, pointer back to A.
